// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// The slave answers a held request with a single-cycle ack.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage.sv
// MIPS32 MEM stage: branch resolution, data-memory access with wait states
// and timeout, MEM/WB register, and upstream stall generation.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_branch,
  input  logic                       i_memread,
  input  logic                       i_memwrite,
  input  logic                       i_memtoreg,
  input  logic                       i_regwrite,
  input  logic                       i_zero,
  input  logic [31:0]                i_branch_target,
  input  logic [31:0]                i_alu_result,
  input  logic [31:0]                i_store_data,
  input  logic [4:0]                 i_write_reg,
  mem_access_stage_if.master         dmem,
  output logic                       pcsrc,
  output logic [31:0]                branch_target_out,
  output logic                       stall,
  output logic                       o_regwrite,
  output logic                       o_memtoreg,
  output logic [31:0]                o_read_data,
  output logic [31:0]                o_alu_result,
  output logic [4:0]                 o_write_reg,
  output logic                       o_misaligned,
  output logic                       o_bus_error
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt, next_cnt;
  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic        latch_en;
  logic        memop;
  logic        req, we, abort, misaligned;
  logic [31:0] addr, wdata;

  assign memop             = i_memread | i_memwrite;
  assign pcsrc             = i_branch & i_zero;
  assign branch_target_out = i_branch_target;

  // The first request cycle comes straight from EX/MEM; later wait cycles replay the latched copy.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    abort      = 1'b0;
    misaligned = 1'b0;
    latch_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (memop) begin
          if (CHECK_ALIGN && (i_alu_result[1:0] != 2'b00)) begin
            misaligned = 1'b1;
          end else begin
            req      = 1'b1;
            we       = i_memwrite;
            addr     = i_alu_result;
            wdata    = i_store_data;
            latch_en = 1'b1;
            if (!dmem.ack) begin
              next_state = ST_WAIT;
              next_cnt   = '0;
            end
          end
        end
      end
      ST_WAIT: begin
        req   = 1'b1;
        we    = lat_we;
        addr  = lat_addr;
        wdata = lat_wdata;
        if (dmem.ack) begin
          next_state = ST_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort      = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_cnt = wait_cnt + 8'd1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (reset) begin
      req        = 1'b0;
      we         = 1'b0;
      addr       = '0;
      wdata      = '0;
      abort      = 1'b0;
      misaligned = 1'b0;
      latch_en   = 1'b0;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = we;
  assign dmem.addr  = addr;
  assign dmem.wdata = wdata;
  assign stall      = req & ~dmem.ack & ~abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (latch_en) begin
        lat_we    <= i_memwrite;
        lat_addr  <= i_alu_result;
        lat_wdata <= i_store_data;
      end
    end
  end

  // Stalled, aborted or rejected cycles insert a bubble; data fields keep their old values.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_regwrite   <= 1'b0;
      o_memtoreg   <= 1'b0;
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_write_reg  <= '0;
      o_misaligned <= 1'b0;
      o_bus_error  <= 1'b0;
    end else begin
      o_misaligned <= misaligned;
      o_bus_error  <= abort;
      if (stall || abort || misaligned) begin
        o_regwrite <= 1'b0;
        o_memtoreg <= 1'b0;
      end else begin
        o_regwrite   <= i_regwrite;
        o_memtoreg   <= i_memtoreg;
        o_alu_result <= i_alu_result;
        o_write_reg  <= i_write_reg;
        if (req && dmem.ack && !i_memwrite) begin
          o_read_data <= dmem.rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a behavioural memory with chosen wait
// counts and an instruction-level model of the MEM/WB outcome.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clock;
  logic        reset;
  logic        i_branch, i_memread, i_memwrite, i_memtoreg, i_regwrite, i_zero;
  logic [31:0] i_branch_target, i_alu_result, i_store_data;
  logic [4:0]  i_write_reg;
  logic        pcsrc, stall, o_regwrite, o_memtoreg, o_misaligned, o_bus_error;
  logic [31:0] branch_target_out, o_read_data, o_alu_result;
  logic [4:0]  o_write_reg;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CHECK_ALIGN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .i_branch(i_branch), .i_memread(i_memread), .i_memwrite(i_memwrite),
    .i_memtoreg(i_memtoreg), .i_regwrite(i_regwrite), .i_zero(i_zero),
    .i_branch_target(i_branch_target), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_write_reg(i_write_reg),
    .dmem(dmem.master),
    .pcsrc(pcsrc), .branch_target_out(branch_target_out), .stall(stall),
    .o_regwrite(o_regwrite), .o_memtoreg(o_memtoreg), .o_read_data(o_read_data),
    .o_alu_result(o_alu_result), .o_write_reg(o_write_reg),
    .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
  );

  typedef struct {
    bit          memread, memwrite, regwrite, memtoreg, branch, zero;
    logic [31:0] addr, sdata, target, rdata;
    logic [4:0]  wreg;
    int          waits;
  } instr_t;

  int n_checks = 0;
  int n_errors = 0;

  bit          exp_rw, exp_mt, exp_mis, exp_berr;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_wreg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_memwb();
    check_output("o_regwrite",   32'(o_regwrite),   32'(exp_rw));
    check_output("o_memtoreg",   32'(o_memtoreg),   32'(exp_mt));
    check_output("o_read_data",  o_read_data,       exp_rd);
    check_output("o_alu_result", o_alu_result,      exp_alu);
    check_output("o_write_reg",  32'(o_write_reg),  32'(exp_wreg));
    check_output("o_misaligned", 32'(o_misaligned), 32'(exp_mis));
    check_output("o_bus_error",  32'(o_bus_error),  32'(exp_berr));
  endtask

  task automatic apply_stimulus(input instr_t ins);
    i_memread       = ins.memread;
    i_memwrite      = ins.memwrite;
    i_regwrite      = ins.regwrite;
    i_memtoreg      = ins.memtoreg;
    i_branch        = ins.branch;
    i_zero          = ins.zero;
    i_alu_result    = ins.addr;
    i_store_data    = ins.sdata;
    i_branch_target = ins.target;
    i_write_reg     = ins.wreg;
  endtask

  task automatic clear_inputs();
    instr_t z;
    z = '{default: 0};
    apply_stimulus(z);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    check_output("reset_req",   32'(dmem.req), 32'd0);
    check_output("reset_stall", 32'(stall),    32'd0);
    exp_rw = 0; exp_mt = 0; exp_mis = 0; exp_berr = 0;
    exp_rd = '0; exp_alu = '0; exp_wreg = '0;
    check_memwb();
    reset = 1'b0;
  endtask

  // Model: an aligned access acked after `waits` cycles completes if waits <= TO, else aborts after TO+1 request cycles.
  task automatic run_instr(input instr_t ins);
    bit memop, mis, access, aborts;
    int cycles;
    memop  = ins.memread | ins.memwrite;
    mis    = memop && (ins.addr[1:0] != 2'b00);
    access = memop && !mis;
    aborts = access && (ins.waits > TO);
    cycles = !access ? 1 : (aborts ? TO + 1 : ins.waits + 1);
    for (int c = 0; c < cycles; c++) begin
      apply_stimulus(ins);
      if (access) begin
        dmem.ack   = (c == ins.waits);
        dmem.rdata = (c == ins.waits) ? ins.rdata : $urandom;
      end else begin
        dmem.ack   = 1'($urandom_range(0, 1));
        dmem.rdata = $urandom;
      end
      #1;
      check_output("pcsrc",  32'(pcsrc), 32'(ins.branch & ins.zero));
      check_output("target", branch_target_out, ins.target);
      check_output("req",    32'(dmem.req), 32'(access));
      if (access) begin
        check_output("addr",  dmem.addr,  ins.addr);
        check_output("we",    32'(dmem.we), 32'(ins.memwrite));
        check_output("wdata", dmem.wdata, ins.sdata);
      end
      check_output("stall", 32'(stall), 32'(access && (c < cycles - 1)));
      @(posedge clock);
      @(negedge clock);
      exp_mis  = 0;
      exp_berr = 0;
      if (c < cycles - 1) begin
        exp_rw = 0; exp_mt = 0;
      end else if (mis) begin
        exp_rw = 0; exp_mt = 0; exp_mis = 1;
      end else if (aborts) begin
        exp_rw = 0; exp_mt = 0; exp_berr = 1;
      end else begin
        exp_rw   = ins.regwrite;
        exp_mt   = ins.memtoreg;
        exp_alu  = ins.addr;
        exp_wreg = ins.wreg;
        if (access && !ins.memwrite) exp_rd = ins.rdata;
      end
      check_memwb();
    end
  endtask

  function automatic instr_t mk(input bit rd, wr, rw, mt, br, zr, input logic [31:0] a, d, t,
                                input logic [4:0] wreg, input int waits, input logic [31:0] rdata);
    instr_t r;
    r.memread = rd; r.memwrite = wr; r.regwrite = rw; r.memtoreg = mt;
    r.branch = br; r.zero = zr; r.addr = a; r.sdata = d; r.target = t;
    r.wreg = wreg; r.waits = waits; r.rdata = rdata;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    int kind;
    kind = $urandom_range(0, 9);
    r = mk(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom), $urandom_range(0, 6), $urandom);
    if (kind >= 3 && kind <= 5) r.memread = 1;
    if (kind >= 6 && kind <= 8) begin r.memwrite = 1; r.memread = 1'($urandom_range(0, 3) == 0); end
    if (kind == 9) begin r.memread = 1; r.addr = $urandom; end
    return r;
  endfunction

  initial begin
    do_reset();

    run_instr(mk(1, 0, 1, 1, 0, 0, 32'h100, 32'h0, 32'h0, 5'd8, 0, 32'hDEADBEEF));
    run_instr(mk(0, 1, 0, 0, 0, 0, 32'h200, 32'h1234, 32'h0, 5'd3, 3, 32'h0));
    run_instr(mk(1, 0, 1, 1, 0, 0, 32'h300, 32'h0, 32'h0, 5'd9, 99, 32'h0));
    run_instr(mk(0, 0, 1, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd4, 0, 32'h0));
    run_instr(mk(1, 0, 1, 1, 0, 0, 32'h102, 32'h0, 32'h0, 5'd5, 0, 32'h0));
    run_instr(mk(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0));
    run_instr(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0));
    run_instr(mk(1, 1, 0, 0, 0, 0, 32'h404, 32'hCAFE, 32'h0, 5'd6, 2, 32'h5555));
    run_instr(mk(1, 0, 1, 1, 0, 0, 32'h408, 32'h0, 32'h0, 5'd7, TO, 32'hA5A5_0001));

    for (int i = 0; i < 300; i++) run_instr(rand_instr());

    // Reset in the middle of an outstanding load; a late ack must not write back.
    apply_stimulus(mk(1, 0, 1, 1, 0, 0, 32'h500, 32'h0, 32'h0, 5'd10, 99, 32'h0));
    dmem.ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_output("wait_stall", 32'(stall), 32'd1);
      @(posedge clock);
      @(negedge clock);
    end
    do_reset();
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hBAD0_BAD0;
    #1;
    check_output("late_ack_req",   32'(dmem.req), 32'd0);
    check_output("late_ack_stall", 32'(stall),    32'd0);
    @(posedge clock);
    @(negedge clock);
    check_memwb();
    dmem.ack = 1'b0;

    for (int i = 0; i < 50; i++) run_instr(rand_instr());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
